fir_tap_ctrl: RTL and testbench

- Controller between the sample stream, the host configuration port and the FIR datapath.
- Holds the 10 live tap coefficients that drive the FIR, plus a shadow bank the host writes.
- Swaps the shadow bank into the live bank atomically at a sample boundary.
- Paces samples into the FIR with a valid/ready handshake and suppresses outputs produced while the delay line holds stale or partial history.

---
 rtl/fir_tap_ctrl.sv | 147 ++++++++++++++
 tb/tb_fir_tap_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_ctrl.sv
// Tap-coefficient and sample-pacing controller for a FIR datapath.
// Host writes a shadow bank; a commit swaps it into the live bank in one sample-free cycle.
module fir_tap_ctrl #(
  parameter int NTAPS   = 10,
  parameter int W       = 16,
  parameter int FIR_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cfg_we,
  input  logic [$clog2(NTAPS)-1:0] cfg_addr,
  input  logic [W-1:0]             cfg_wdata,
  input  logic                     cfg_commit,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic                     fir_en,
  output logic [W-1:0]             fir_xin,
  output logic [NTAPS-1:0][W-1:0]  taps,
  input  logic [W-1:0]             fir_y,
  output logic                     out_valid,
  output logic [W-1:0]             out_data
);

  localparam int AW = $clog2(NTAPS);
  localparam int CW = $clog2(NTAPS + 1);
  localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(NTAPS);
  localparam logic [CW-1:0] FILL_MAX   = CW'(NTAPS);
  localparam logic [CW-1:0] FILL_LAST  = CW'(NTAPS - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     cfg_busy_q, cfg_busy_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     in_ready_q, in_ready_d;
  logic [NTAPS-1:0][W-1:0]  live_q, live_d;
  logic [NTAPS-1:0][W-1:0]  shadow_q, shadow_d;
  logic [CW-1:0]            fill_q, fill_d;
  logic [FIR_LAT-1:0]       tag_vld_q, tag_vld_d;
  logic [FIR_LAT-1:0]       tag_qual_q, tag_qual_d;
  logic                     accept;
  logic                     addr_ok;
  logic                     start_swap;

  always_comb begin
    accept     = in_valid && in_ready_q;
    addr_ok    = ({1'b0, cfg_addr} < ADDR_LIMIT);
    start_swap = (state_q == ST_IDLE) && cfg_commit;

    state_d    = state_q;
    cfg_busy_d = cfg_busy_q;
    cfg_err_d  = 1'b0;
    shadow_d   = shadow_q;
    live_d     = live_q;
    fill_d     = fill_q;

    case (state_q)
      ST_IDLE: begin
        // A write in the commit cycle lands in shadow first, so the swap picks it up.
        for (int i = 0; i < NTAPS; i++) begin
          if (cfg_we && addr_ok && (cfg_addr == AW'(i))) begin
            shadow_d[i] = cfg_wdata;
          end
        end
        if (cfg_we && !addr_ok) begin
          cfg_err_d = 1'b1;
        end
        if (accept) begin
          fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
        end
        if (cfg_commit) begin
          state_d    = ST_PENDING;
          cfg_busy_d = 1'b1;
        end
      end
      ST_PENDING: begin
        live_d     = shadow_q;
        fill_d     = '0;
        state_d    = ST_IDLE;
        cfg_busy_d = 1'b0;
        cfg_err_d  = cfg_we || cfg_commit;
      end
      default: begin
        state_d    = ST_IDLE;
        cfg_busy_d = 1'b0;
      end
    endcase

    // in_ready low for exactly the swap cycle keeps taps stable whenever fir_en is high.
    in_ready_d = (state_d == ST_IDLE);

    tag_vld_d     = tag_vld_q;
    tag_qual_d    = tag_qual_q;
    tag_vld_d[0]  = accept;
    tag_qual_d[0] = accept && (fill_q >= FILL_LAST);
    for (int i = 1; i < FIR_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_qual_d[i] = tag_qual_q[i-1];
    end
    // Outputs computed from pre-swap history are dropped, including the one entering now.
    if (start_swap) begin
      tag_qual_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cfg_busy_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      in_ready_q <= 1'b0;
      live_q     <= '0;
      shadow_q   <= '0;
      fill_q     <= '0;
      tag_vld_q  <= '0;
      tag_qual_q <= '0;
    end else begin
      state_q    <= state_d;
      cfg_busy_q <= cfg_busy_d;
      cfg_err_q  <= cfg_err_d;
      in_ready_q <= in_ready_d;
      live_q     <= live_d;
      shadow_q   <= shadow_d;
      fill_q     <= fill_d;
      tag_vld_q  <= tag_vld_d;
      tag_qual_q <= tag_qual_d;
    end
  end

  // The emerging tag lines up with the cycle in which the FIR presents its result.
  assign out_valid = tag_vld_q[FIR_LAT-1] && tag_qual_q[FIR_LAT-1];
  assign out_data  = out_valid ? fir_y : '0;

  assign cfg_busy = cfg_busy_q;
  assign cfg_err  = cfg_err_q;
  assign in_ready = in_ready_q;
  assign fir_en   = accept;
  assign fir_xin  = accept ? in_data : '0;
  assign taps     = live_q;

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Directed self-checking bench for fir_tap_ctrl; a simple one-cycle FIR stub drives fir_y.
module tb_fir_tap_ctrl;

  localparam int NTAPS = 10;
  localparam int W     = 16;
  localparam int AW    = $clog2(NTAPS);

  logic                    clock   = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    cfg_we;
  logic [AW-1:0]           cfg_addr;
  logic [W-1:0]            cfg_wdata;
  logic                    cfg_commit;
  logic                    cfg_busy;
  logic                    cfg_err;
  logic                    in_valid;
  logic [W-1:0]            in_data;
  logic                    in_ready;
  logic                    fir_en;
  logic [W-1:0]            fir_xin;
  logic [NTAPS-1:0][W-1:0] taps;
  logic [W-1:0]            fir_y = '0;
  logic                    out_valid;
  logic [W-1:0]            out_data;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] coef [NTAPS] = '{16'h0F85, 16'h079E, 16'h08D8, 16'h09C0, 16'h0A3C,
                                 16'h0A3C, 16'h09C0, 16'h08D8, 16'h079E, 16'h0F85};
  logic [W-1:0] exp_taps [NTAPS];

  fir_tap_ctrl #(.NTAPS(NTAPS), .W(W), .FIR_LAT(1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fir_en     (fir_en),
    .fir_xin    (fir_xin),
    .taps       (taps),
    .fir_y      (fir_y),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  always #5 clock = ~clock;

  // FIR stub: result of a sample appears one clock after its fir_en.
  always @(posedge clock) begin
    if (fir_en) fir_y <= fir_xin ^ 16'h5A5A;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                               input logic commit, input logic valid, input logic [W-1:0] data);
    cfg_we     = we;
    cfg_addr   = addr;
    cfg_wdata  = wdata;
    cfg_commit = commit;
    in_valid   = valid;
    in_data    = data;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkTaps(input string tag);
    for (int i = 0; i < NTAPS; i++) begin
      checkOutput($sformatf("%s_tap%0d", tag, i), 32'(taps[i]), 32'(exp_taps[i]));
    end
  endtask

  initial begin
    logic [W-1:0] s;
    logic         exp_rdy;
    logic         exp_ov;

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1 reset_n = 1'b0;
    #2;
    $display("[TB] reset checks");
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(cfg_busy), 32'd0);
    checkOutput("rst_err", 32'(cfg_err), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_fir_en", 32'(fir_en), 32'd0);
    for (int i = 0; i < NTAPS; i++) exp_taps[i] = '0;
    checkTaps("rst0");
    #19 reset_n = 1'b1;
    step();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] load shadow bank and commit");
    for (int i = 0; i < NTAPS; i++) begin
      applyStimulus(1'b1, AW'(i), coef[i], 1'b0, 1'b0, '0);
      step();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("swap1_busy_hi", 32'(cfg_busy), 32'd1);
    checkOutput("swap1_ready_lo", 32'(in_ready), 32'd0);
    checkOutput("swap1_tap0_old", 32'(taps[0]), 32'd0);
    step();
    checkOutput("swap1_busy_lo", 32'(cfg_busy), 32'd0);
    checkOutput("swap1_ready_hi", 32'(in_ready), 32'd1);
    for (int i = 0; i < NTAPS; i++) exp_taps[i] = coef[i];
    checkTaps("swap1");

    $display("[TB] stream 20 samples");
    for (int k = 0; k < 20; k++) begin
      s = 16'h1000 + 16'(k * 257);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, s);
      #1;
      checkOutput($sformatf("st_fir_en%0d", k), 32'(fir_en), 32'd1);
      checkOutput($sformatf("st_fir_xin%0d", k), 32'(fir_xin), 32'(s));
      step();
      exp_ov = (k >= 9);
      checkOutput($sformatf("st_out_valid%0d", k), 32'(out_valid), 32'(exp_ov));
      checkOutput($sformatf("st_out_data%0d", k), 32'(out_data), exp_ov ? 32'(s ^ 16'h5A5A) : 32'd0);
    end

    $display("[TB] commit mid-stream");
    for (int c = 0; c <= 12; c++) begin
      s = 16'h2000 + 16'(c);
      applyStimulus(c == 0, '0, 16'h0111, c == 1, 1'b1, s);
      exp_rdy = (c != 2);
      #1;
      checkOutput($sformatf("ms_in_ready%0d", c), 32'(in_ready), 32'(exp_rdy));
      checkOutput($sformatf("ms_fir_en%0d", c), 32'(fir_en), 32'(exp_rdy));
      step();
      exp_ov = (c == 0) || (c == 12);
      checkOutput($sformatf("ms_out_valid%0d", c), 32'(out_valid), 32'(exp_ov));
      if (exp_ov)
        checkOutput($sformatf("ms_out_data%0d", c), 32'(out_data), 32'(s ^ 16'h5A5A));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    exp_taps[0] = 16'h0111;
    checkTaps("swap2");
    step();

    $display("[TB] rejected writes");
    applyStimulus(1'b1, 4'd12, 16'hFFFF, 1'b0, 1'b0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("bad_addr_err", 32'(cfg_err), 32'd1);
    step();
    checkOutput("bad_addr_err_pulse", 32'(cfg_err), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    step();
    checkOutput("pend_busy", 32'(cfg_busy), 32'd1);
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, '0);
    step();
    checkOutput("pend_we_err", 32'(cfg_err), 32'd1);
    checkOutput("pend_we_busy_lo", 32'(cfg_busy), 32'd0);

    $display("[TB] write and commit same cycle");
    applyStimulus(1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, '0);
    step();
    checkOutput("wc_err", 32'(cfg_err), 32'd0);
    checkOutput("wc_busy", 32'(cfg_busy), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("pend_commit_err", 32'(cfg_err), 32'd1);
    checkOutput("wc_busy_lo", 32'(cfg_busy), 32'd0);
    exp_taps[5] = 16'h1234;
    checkTaps("swap3");
    step();
    checkOutput("pend_commit_ignored", 32'(cfg_busy), 32'd0);
    checkOutput("pend_commit_err_pulse", 32'(cfg_err), 32'd0);

    $display("[TB] reset with commit pending");
    applyStimulus(1'b1, 4'd1, 16'h7777, 1'b0, 1'b1, 16'h3001);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 16'h3002);
    step();
    checkOutput("mid_busy", 32'(cfg_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_in_ready", 32'(in_ready), 32'd0);
    checkOutput("async_fir_en", 32'(fir_en), 32'd0);
    checkOutput("async_fir_xin", 32'(fir_xin), 32'd0);
    checkOutput("async_busy", 32'(cfg_busy), 32'd0);
    checkOutput("async_err", 32'(cfg_err), 32'd0);
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_out_data", 32'(out_data), 32'd0);
    for (int i = 0; i < NTAPS; i++) exp_taps[i] = '0;
    checkTaps("async");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rel_busy", 32'(cfg_busy), 32'd0);
    step();
    step();
    checkTaps("no_swap");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    step();
    checkTaps("shadow_lost");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
